gpio_in_capture: RTL and testbench
==================================

# gpio_in_capture

- Input-side companion to the GPIO output register: receives asynchronous external pins and synchronizes and debounces each bit.
- Detects per-bit rising and falling edges and latches them into write-1-to-clear pending bits.
- Drives a single level interrupt to the core.
- Sits between the pad inputs and the memory-mapped register file, which supplies enables and clear strobes and reads level/pending.

## Interface
Parameters:
- WIDTH, 32, number of GPIO input bits.
- DEBOUNCE_CYCLES, 4, cycles a synchronized value must differ from the current level before it is accepted (≥1).

Ports:
- clk  in  1  single clock for all state.
- rst_n  in  1  asynchronous, active-low reset; clears all state.
- gpio_in  in  WIDTH  raw pad inputs, asynchronous to clk.
- rise_en  in  WIDTH  per-bit rising-edge capture enable.
- fall_en  in  WIDTH  per-bit falling-edge capture enable.
- clear_valid  in  1  one-cycle strobe qualifying clear_mask.
- clear_mask  in  WIDTH  pending bits to clear (write-1-to-clear).
- level_out  out  WIDTH  debounced pin level.
- pending  out  WIDTH  latched edge events.
- irq  out  1  registered OR of pending.

## Operation
Synchronizer:
- Two flops per bit: sync1 then sync2. No logic between them.

Debounce, per bit, with counter cnt of width $clog2(DEBOUNCE_CYCLES+1):
- sync2 == level: cnt <= 0.
- sync2 != level and cnt == DEBOUNCE_CYCLES-1: level <= sync2, cnt <= 0, assert accept for that edge.
- Otherwise: cnt <= cnt+1.
- Any return of sync2 to level before acceptance restarts the count. Pulses shorter than DEBOUNCE_CYCLES cycles at sync2 never reach level_out.

Edge capture:
- set[i] = accept[i] & ((sync2[i] & rise_en[i]) | (~sync2[i] & fall_en[i])).
- pending <= (pending & ~(clear_valid ? clear_mask : 0)) | set.
- Set wins over clear on the same bit in the same cycle.
- Enables are sampled only in the accept cycle. Changing an enable never creates or removes an existing pending bit.
- Pending bits stay set until cleared. Repeated edges do not count; there is no overflow indication.

Interrupt:
- irq <= |pending_next, where pending_next is the value being written into pending. irq is registered.

## Timing
- Reset (rst_n low, immediate, no clock needed): sync1, sync2, level_out, cnt, pending and irq all 0.
- Latency, with the pin stable from before sampling edge E1:
  - sync2 updates at E2.
  - level_out and pending update at E(2+DEBOUNCE_CYCLES).
  - irq rises at the same edge as pending.
  - Default DEBOUNCE_CYCLES=4: level_out/pending/irq at E6.
- DEBOUNCE_CYCLES=1: level follows sync2 one edge later (E3).
- Clear: clear_valid at edge C drops pending and irq at C, provided no other bit remains set and no new set occurs.
- Reset released with pins high: level rises after 2+DEBOUNCE_CYCLES edges and reports a rising edge if enabled. This is required behaviour.
- Reset asserted mid-debounce: cnt is discarded, and counting restarts from a level of 0.

## Structure
- Shared package gpio_pkg holds:
  - GPIO_WIDTH (32).
  - GPIO_DEBOUNCE_CYCLES (4).
  - Bit-index localparams for the register-file offsets of level, pending, rise_en and fall_en.
- Sub-module gpio_debounce (one bit): synchronizer, counter, level and accept. It is instantiated WIDTH times via generate.
- Edge qualification, pending and irq stay in the top-level gpio_in_capture.

## Test plan
- Reset: drive gpio_in=0xFFFF_FFFF with rst_n=0 → level_out, pending and irq read 0 with no clock running. Release rst_n with rise_en=0 → level_out=0xFFFF_FFFF at E6 and pending stays 0.
- Rising capture: rise_en=0x1, bit0 goes 0→1 before E1 → level_out[0]=1, pending=0x1 and irq=1 all at E6, not at E5.
- Glitch reject: DEBOUNCE_CYCLES=4, bit5 pulses high for 3 cycles → level_out[5], pending[5] and irq never change. The same bit held high for 4 cycles is accepted.
- Disabled direction: fall_en=0, rise_en=0x8, bit3 goes 1→0 → level_out[3]=0 and pending[3]=0. Then 0→1 → pending=0x8.
- Simultaneous set and clear:
  - Setup: pending=0x4, bit2 accept cycle coincides with clear_valid=1, clear_mask=0x6 → pending stays 0x4.
  - Follow-up: next clear of 0x4 → pending=0 and irq=0 at that edge.
- Async reset mid-debounce: bit7 cnt=2 and pending=0xFF, pull rst_n low between edges → all outputs 0 immediately. After release, bit7 (still high) needs a full 2+4 edges to reach level_out.

Source files
------------

// File: rtl/gpio_pkg.sv
// Shared GPIO constants: default sizing and register-file bit indices.
package gpio_pkg;

  localparam int GPIO_WIDTH           = 32;
  localparam int GPIO_DEBOUNCE_CYCLES = 4;

  // Word indices of the input-side registers in the GPIO register file
  localparam int GPIO_REG_LEVEL_IDX   = 0;
  localparam int GPIO_REG_PENDING_IDX = 1;
  localparam int GPIO_REG_RISE_EN_IDX = 2;
  localparam int GPIO_REG_FALL_EN_IDX = 3;

  typedef struct packed {
    logic sync;
    logic level;
    logic accept;
  } gpio_db_t;

endpackage

// File: rtl/gpio_debounce.sv
// One GPIO input bit: two-flop synchronizer followed by a stability counter.
module gpio_debounce
  import gpio_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = GPIO_DEBOUNCE_CYCLES
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     din,
  output gpio_db_t db
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1, sync2, level;
  logic [CW-1:0] cnt;
  logic          accept;

  // cnt holds how many consecutive cycles sync2 has already disagreed with level
  assign accept = (sync2 != level) && (cnt == CNT_LAST);
  assign db     = '{sync: sync2, level: level, accept: accept};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      level <= 1'b0;
      cnt   <= '0;
    end else begin
      sync1 <= din;
      sync2 <= sync1;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (accept) begin
        level <= sync2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/gpio_in_capture.sv
// GPIO input capture: per-bit debounce, enabled edge latching into W1C pending, level irq.
module gpio_in_capture
  import gpio_pkg::*;
#(
  parameter int WIDTH           = GPIO_WIDTH,
  parameter int DEBOUNCE_CYCLES = GPIO_DEBOUNCE_CYCLES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] gpio_in,
  input  logic [WIDTH-1:0] rise_en,
  input  logic [WIDTH-1:0] fall_en,
  input  logic             clear_valid,
  input  logic [WIDTH-1:0] clear_mask,
  output logic [WIDTH-1:0] level_out,
  output logic [WIDTH-1:0] pending,
  output logic             irq
);

  logic [WIDTH-1:0] sync2, accept, set, pending_next;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    gpio_db_t db;
    gpio_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk   (clk),
      .rst_n (rst_n),
      .din   (gpio_in[i]),
      .db    (db)
    );
    assign sync2[i]     = db.sync;
    assign accept[i]    = db.accept;
    assign level_out[i] = db.level;
  end

  // Enables only matter in the accept cycle; set overrides a same-cycle clear
  assign set          = accept & ((sync2 & rise_en) | (~sync2 & fall_en));
  assign pending_next = (pending & ~(clear_valid ? clear_mask : '0)) | set;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= '0;
      irq     <= 1'b0;
    end else begin
      pending <= pending_next;
      irq     <= |pending_next;
    end
  end

endmodule

// File: tb/tb_gpio_in_capture.sv
// Self-checking bench for gpio_in_capture: directed table, corner sequences, random vs model.
module tb_gpio_in_capture;
  import gpio_pkg::*;

  localparam int W = GPIO_WIDTH;
  localparam int D = GPIO_DEBOUNCE_CYCLES;

  logic         clk = 1'b0;
  logic         clk_en = 1'b0;
  logic         rst_n;
  logic [W-1:0] gpio_in, rise_en, fall_en, clear_mask;
  logic         clear_valid;
  logic [W-1:0] level_out, pending;
  logic         irq;

  gpio_in_capture #(.WIDTH(W), .DEBOUNCE_CYCLES(D)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .gpio_in     (gpio_in),
    .rise_en     (rise_en),
    .fall_en     (fall_en),
    .clear_valid (clear_valid),
    .clear_mask  (clear_mask),
    .level_out   (level_out),
    .pending     (pending),
    .irq         (irq)
  );

  always begin
    #5;
    if (clk_en) clk = ~clk;
  end

  int total = 0;
  int bad   = 0;

  // Reference model: a pin sample is accepted once the last D synchronized
  // samples all disagree with the current level.
  logic [W-1:0] m_s1, m_s2, m_lvl, m_pend;
  logic         m_irq;
  logic [W-1:0] m_hist [D];

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic m_clear();
    m_s1 = '0; m_s2 = '0; m_lvl = '0; m_pend = '0; m_irq = 1'b0;
    for (int k = 0; k < D; k++) m_hist[k] = '0;
  endtask

  task automatic chk_model(input string nm);
    chk({nm, " level"},   level_out, m_lvl);
    chk({nm, " pending"}, pending,   m_pend);
    chk({nm, " irq"},     W'(irq),   W'(m_irq));
  endtask

  // One clock: model advances on the same edge, then DUT compared 1ns later
  task automatic cyc();
    logic [W-1:0] diff, acc, set, pn;
    diff = '1;
    for (int k = 0; k < D; k++) diff &= (m_hist[k] ^ m_lvl);
    acc = diff;
    set = acc & ((m_s2 & rise_en) | (~m_s2 & fall_en));
    pn  = (m_pend & ~(clear_valid ? clear_mask : '0)) | set;
    @(posedge clk);
    #1;
    if (!rst_n) begin
      m_clear();
    end else begin
      m_pend = pn;
      m_irq  = (pn != '0);
      m_lvl  = m_lvl ^ acc;
      m_s2   = m_s1;
      m_s1   = gpio_in;
      for (int k = D - 1; k > 0; k--) m_hist[k] = m_hist[k-1];
      m_hist[0] = m_s2;
    end
    chk_model("model");
  endtask

  task automatic cycn(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  // Entered 1ns after an edge; asserts reset between edges
  task automatic do_reset();
    #1;
    rst_n = 1'b0;
    m_clear();
    #1;
    chk("rst level", level_out, '0);
    chk("rst pending", pending, '0);
    chk("rst irq", W'(irq), '0);
    rst_n = 1'b1;
  endtask

  task automatic clear_all();
    clear_valid = 1'b1; clear_mask = '1;
    cyc();
    clear_valid = 1'b0; clear_mask = '0;
  endtask

  typedef struct {
    logic [W-1:0] pin0, pin1, re, fe;
    logic [W-1:0] exp_lvl, exp_pend;
  } vec_t;

  vec_t tbl [6];

  initial begin
    tbl[0] = '{32'h0000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    tbl[1] = '{32'hFFFF_FFFF, 32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000};
    tbl[2] = '{32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0000, 32'h0F0F_0F0F, 32'h0000_0000, 32'h0F0F_0F0F};
    tbl[3] = '{32'hA5A5_0000, 32'h5A5A_FFFF, 32'hFFFF_0000, 32'h0000_FFFF, 32'h5A5A_FFFF, 32'h5A5A_0000};
    tbl[4] = '{32'h1234_5678, 32'h1234_5678, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1234_5678, 32'h0000_0000};
    tbl[5] = '{32'h0000_00F0, 32'h0000_000F, 32'h0000_000F, 32'h0000_00F0, 32'h0000_000F, 32'h0000_00FF};

    m_clear();
    rst_n = 1'b0; gpio_in = '1; rise_en = '0; fall_en = '0;
    clear_valid = 1'b0; clear_mask = '0;

    // Reset state with no clock running
    #3;
    chk("noclk level", level_out, '0);
    chk("noclk pending", pending, '0);
    chk("noclk irq", W'(irq), '0);
    clk_en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    cycn(D + 1);
    chk("post-rst E5 level", level_out, '0);
    cyc();
    chk("post-rst E6 level", level_out, '1);
    chk("post-rst pending", pending, '0);

    // Rising capture on bit0: visible at E6, not E5
    gpio_in = '0;
    do_reset();
    cycn(8);
    rise_en = 32'h1; gpio_in = 32'h1;
    cycn(D + 1);
    chk("rise E5 pending", pending, '0);
    chk("rise E5 irq", W'(irq), '0);
    cyc();
    chk("rise E6 level", level_out, 32'h1);
    chk("rise E6 pending", pending, 32'h1);
    chk("rise E6 irq", W'(irq), 1);
    clear_all();
    chk("rise clear irq", W'(irq), '0);

    // Glitch reject on bit5, then an accepted 4-cycle pulse
    rise_en = 32'h20;
    gpio_in = 32'h21;
    cycn(3);
    gpio_in = 32'h1;
    for (int i = 0; i < 8; i++) begin
      cyc();
      chk("glitch level", level_out, 32'h1);
      chk("glitch pending", pending, '0);
    end
    gpio_in = 32'h21;
    cycn(4);
    gpio_in = 32'h1;
    cycn(10);
    chk("pulse4 pending", pending, 32'h20);
    clear_all();

    // Disabled falling direction on bit3
    rise_en = '0; fall_en = '0;
    gpio_in = 32'h9;
    cycn(8);
    rise_en = 32'h8;
    gpio_in = 32'h1;
    cycn(8);
    chk("nofall level", level_out, 32'h1);
    chk("nofall pending", pending, '0);
    gpio_in = 32'h9;
    cycn(8);
    chk("rise3 pending", pending, 32'h8);
    clear_all();

    // Set and clear on the same bit in the same cycle
    rise_en = 32'h4; fall_en = '0;
    gpio_in = 32'h5;
    cycn(8);
    chk("setup pending", pending, 32'h4);
    fall_en = 32'h4;
    gpio_in = 32'h1;
    cycn(D + 1);
    clear_valid = 1'b1; clear_mask = 32'h6;
    cyc();
    chk("set-vs-clear pending", pending, 32'h4);
    clear_mask = 32'h4;
    cyc();
    clear_valid = 1'b0; clear_mask = '0;
    chk("followup pending", pending, '0);
    chk("followup irq", W'(irq), '0);

    // Async reset while bit7 is mid-debounce
    gpio_in = '0; rise_en = '0; fall_en = '0;
    do_reset();
    rise_en = 32'hFF;
    gpio_in = 32'hFF;
    cycn(8);
    gpio_in = 32'h7F;
    cycn(8);
    chk("pre-mid pending", pending, 32'hFF);
    gpio_in = 32'hFF;
    cycn(4);
    do_reset();
    cycn(D + 1);
    chk("mid-rst E5 level", level_out, '0);
    cyc();
    chk("mid-rst E6 level", level_out, 32'hFF);
    chk("mid-rst E6 pending", pending, 32'hFF);

    // Table-driven single-transition vectors
    for (int t = 0; t < 6; t++) begin
      rise_en = '0; fall_en = '0;
      gpio_in = tbl[t].pin0;
      do_reset();
      cycn(8);
      clear_all();
      rise_en = tbl[t].re; fall_en = tbl[t].fe;
      gpio_in = tbl[t].pin1;
      cycn(8);
      chk($sformatf("tbl%0d level", t), level_out, tbl[t].exp_lvl);
      chk($sformatf("tbl%0d pending", t), pending, tbl[t].exp_pend);
    end

    // Random sparse toggling, enable changes and clears against the model
    gpio_in = $urandom;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      gpio_in ^= $urandom & $urandom & $urandom & $urandom;
      if (i % 50 == 0) begin
        rise_en = $urandom;
        fall_en = $urandom;
      end
      clear_valid = ($urandom_range(0, 7) == 0);
      clear_mask  = $urandom;
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
